// File: rtl/i2c_mem_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_mem_target
// Description : I2C target with a byte-wide memory behind an auto-incrementing
//               pointer. SCL/SDA are oversampled on clk. START and STOP are
//               recognised in every state. The target ACKs its own address.
//               A write carries a pointer byte followed by data bytes. A read
//               streams bytes starting at the current pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_mem_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         PTR_W    = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_pulse,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data
);

    localparam int               c_DEPTH   = 2 ** PTR_W;
    localparam logic [PTR_W-1:0] c_PTR_ONE = 1;

    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_ADDR      = 4'd1;
    localparam logic [3:0] c_S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] c_S_PTR       = 4'd3;
    localparam logic [3:0] c_S_PTR_ACK   = 4'd4;
    localparam logic [3:0] c_S_WDATA     = 4'd5;
    localparam logic [3:0] c_S_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_S_RDATA     = 4'd7;
    localparam logic [3:0] c_S_RDATA_ACK = 4'd8;
    localparam logic [3:0] c_S_WAIT_STOP = 4'd9;

    logic [1:0]       r_scl_s, r_sda_s;
    logic             r_scl_d, r_sda_d;
    logic [3:0]       r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_rw, w_rw_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_sda_oe, w_sda_oe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_wr_en;
    logic             r_wr_pulse;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_mem [c_DEPTH];

    logic       w_scl, w_sda;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte_in, w_mem_rd;

    assign w_scl      = r_scl_s[1];
    assign w_sda      = r_sda_s[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be stably high across the SDA transition for START/STOP.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte_in  = {r_shift[6:0], w_sda};
    assign w_mem_rd   = r_mem[r_ptr];

    // Two-flop synchronisers plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_scl_s <= 2'b11;
            r_sda_s <= 2'b11;
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], scl_i};
            r_sda_s <= {r_sda_s[0], sda_i};
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // Protocol state register and its datapath.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= 4'd0;
            r_shift  <= 8'd0;
            r_rw     <= 1'b0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_rw     <= w_rw_nxt;
            r_ptr    <= w_ptr_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state decode: START/STOP first, then bit handling on synchronised SCL edges.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_rw_nxt     = r_rw;
        w_ptr_nxt    = r_ptr;
        w_sda_oe_nxt = r_sda_oe;
        w_busy_nxt   = r_busy;
        w_wr_en      = 1'b0;
        if (w_stop) begin
            w_state_nxt  = c_S_IDLE;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = c_S_ADDR;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                c_S_ADDR, c_S_PTR, c_S_WDATA: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_shift_nxt = w_byte_in;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        // A data byte commits on its eighth rising edge.
                        if (r_state == c_S_WDATA && r_cnt == 4'd7) begin
                            w_wr_en   = 1'b1;
                            w_ptr_nxt = r_ptr + c_PTR_ONE;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_sda_oe_nxt = 1'b1;
                        if (r_state == c_S_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_state_nxt = c_S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = r_shift[0];
                            end else begin
                                w_state_nxt  = c_S_WAIT_STOP;
                                w_sda_oe_nxt = 1'b0;
                                w_busy_nxt   = 1'b0;
                            end
                        end else if (r_state == c_S_PTR) begin
                            w_state_nxt = c_S_PTR_ACK;
                            w_ptr_nxt   = r_shift[PTR_W-1:0];
                        end else begin
                            w_state_nxt = c_S_WDATA_ACK;
                        end
                    end
                end
                c_S_ADDR_ACK, c_S_PTR_ACK, c_S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 4'd0;
                        if (r_state == c_S_ADDR_ACK && r_rw) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            w_state_nxt  = c_S_RDATA;
                            w_shift_nxt  = w_mem_rd;
                            w_sda_oe_nxt = ~w_mem_rd[7];
                        end else if (r_state == c_S_ADDR_ACK) begin
                            w_state_nxt = c_S_PTR;
                        end else begin
                            w_state_nxt = c_S_WDATA;
                        end
                    end
                end
                c_S_RDATA: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_state_nxt  = c_S_RDATA_ACK;
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 4'd0;
                        w_ptr_nxt    = r_ptr + c_PTR_ONE;
                    end else if (w_scl_fall && r_cnt != 4'd0) begin
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
                c_S_RDATA_ACK: begin
                    // r_cnt == 1 marks an ACK seen on the ninth rising edge.
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt  = c_S_WAIT_STOP;
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = 4'd1;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_state_nxt  = c_S_RDATA;
                        w_cnt_nxt    = 4'd0;
                        w_shift_nxt  = w_mem_rd;
                        w_sda_oe_nxt = ~w_mem_rd[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (Reset && w_wr_en) begin
            r_mem[r_ptr] <= w_byte_in;
        end
    end

    // Write strobe with the address and data it reports.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
        end else begin
            r_wr_pulse <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte_in;
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire
